// File: rtl/sdram_row_reader.sv
// rtl/sdram_row_reader.sv - read-side row scheduler: row burst request, beat forwarding, pointer advance
//
// Whenever the SDRAM buffer holds unread rows (sdram_empty=0) and en is high,
// one full-row read burst is requested at the current read pointer.
// The returned beats are forwarded with one cycle of latency.
// When the row has been consumed, incr_rd_ptr pulses once.
//
// Optional feature macro: SDRAM_ROW_READER_CHECK_EN compiles in an incrementing-pattern
// checker driving err/err_cnt. With it undefined, both outputs are tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                run enable, sampled only in IDLE
//   sdram_empty       write pointer == read pointer
//   rd_row, rd_bank   current read pointer, latched into req_row/req_bank
//   incr_rd_ptr       one-cycle read-pointer advance pulse
//   req, ack          row read request handshake with the SDRAM controller
//   req_row, req_bank address held stable for the request
//   rd_valid, rd_data read data beats from the controller
//   out_valid/out_data/out_last  registered beat stream, no backpressure
//   busy              high in any state other than IDLE
//   rows_read         completed row count, wrapping
//   err, err_cnt      sticky pattern mismatch flag and saturating mismatch count

module sdram_row_reader #(
    parameter int ROW_W     = 13,
    parameter int BANK_W    = 2,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sdram_empty,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              incr_rd_ptr,
    output logic              req,
    output logic [ROW_W-1:0]  req_row,
    output logic [BANK_W-1:0] req_bank,
    input  logic              ack,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       rows_read,
    output logic              err,
    output logic [15:0]       err_cnt
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        DATA   = 3'd2,
        ADV    = 3'd3,
        SETTLE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  beat_cnt_q;
    logic [ROW_W-1:0]  req_row_q;
    logic [BANK_W-1:0] req_bank_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic [15:0]       rows_read_q;

    logic latch_addr;
    logic beat_fire;
    logic last_beat;

    // Beats only count while in DATA; anything arriving before ack or after
    // the row is complete is dropped here.
    assign beat_fire = (state_q == DATA) && rd_valid;
    assign last_beat = beat_fire && (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        latch_addr = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !sdram_empty) begin
                    state_d    = REQ;
                    latch_addr = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_beat) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                state_d = SETTLE;
            end
            // One spare cycle so sdram_empty reflects the advanced pointer
            // before IDLE looks at it again.
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            req_row_q   <= '0;
            req_bank_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            rows_read_q <= '0;
        end else begin
            state_q <= state_d;

            if (latch_addr) begin
                req_row_q  <= rd_row;
                req_bank_q <= rd_bank;
            end

            if (latch_addr || last_beat) begin
                beat_cnt_q <= '0;
            end else if (beat_fire) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end

            out_valid_q <= beat_fire;
            out_last_q  <= last_beat;
            if (beat_fire) begin
                out_data_q <= rd_data;
            end

            if (state_q == ADV) begin
                rows_read_q <= rows_read_q + 16'd1;
            end
        end
    end

    assign req         = (state_q == REQ);
    assign incr_rd_ptr = (state_q == ADV);
    assign busy        = (state_q != IDLE);
    assign req_row     = req_row_q;
    assign req_bank    = req_bank_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign rows_read   = rows_read_q;

`ifdef SDRAM_ROW_READER_CHECK_EN
    // The expected word runs across rows and advances on every counted beat.
    // This way, a single corrupted beat does not misalign the rest of the stream.
    logic [DATA_W-1:0] exp_word_q;
    logic              err_q;
    logic [15:0]       err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_word_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else if (beat_fire) begin
            exp_word_q <= exp_word_q + DATA_W'(1);
            if (rd_data != exp_word_q) begin
                err_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    assign err     = 1'b0;
    assign err_cnt = 16'd0;
`endif

endmodule

// File: doc/sdram_row_reader.md
# sdram_row_reader

Read-side row scheduler for the SDRAM stream test. Whenever the SDRAM buffer holds unread rows, it requests a full-row read burst from the SDRAM controller at the current read pointer. It forwards the returned words as a registered stream and pulses the read-pointer increment once the row has been consumed. It is the consumer of the write/read pointer pair, sitting between the pointer block, the SDRAM controller read port and the downstream stream sink.

## Interface
Parameters:
- ROW_W, 13, row address width
- BANK_W, 2, bank address width
- DATA_W, 16, SDRAM data word width
- BURST_LEN, 512, words per row burst (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; sampled only in IDLE
- sdram_empty  in  1  high when write and read pointers are equal
- rd_row  in  ROW_W  current read-pointer row
- rd_bank  in  BANK_W  current read-pointer bank
- incr_rd_ptr  out  1  one-cycle pulse that advances the read pointer
- req  out  1  row read request to the SDRAM controller
- req_row  out  ROW_W  latched row for the request
- req_bank  out  BANK_W  latched bank for the request
- ack  in  1  controller accepted the request
- rd_valid  in  1  read data beat valid
- rd_data  in  DATA_W  read data beat
- out_valid  out  1  forwarded beat valid
- out_data  out  DATA_W  forwarded beat
- out_last  out  1  marks the final beat of a row
- busy  out  1  high in any state except IDLE
- rows_read  out  16  count of completed rows; wraps at 2^16
- err  out  1  sticky pattern mismatch (checker only)
- err_cnt  out  16  mismatch count, saturating (checker only)

## Operation
- FSM states: IDLE, REQ, DATA, ADV, SETTLE.
- IDLE -> REQ when en=1 and sdram_empty=0. On this transition, rd_row and rd_bank are latched into req_row and req_bank.
- REQ: req=1 and the latched address is held stable. On ack=1 -> DATA. With no ack, the block stays in REQ indefinitely.
- DATA: each rd_valid=1 increments the beat counter (width clog2(BURST_LEN+1)). The beat with counter value BURST_LEN-1 is the last beat -> ADV.
- ADV: incr_rd_ptr=1 for exactly one cycle, and rows_read increments -> SETTLE.
- SETTLE: waits one cycle so that sdram_empty reflects the new pointer -> IDLE.
- rd_valid outside DATA is ignored: it is not forwarded, not counted and not checked.
- Deasserting en mid-row does not abort the row. The row completes normally, then the block stays in IDLE.
- Outputs are never forwarded from beats that arrive before ack.
- Pointer wrap-around belongs to the pointer block. req_row/req_bank carry the pointer value as-is, including a wrap from the highest bank/row to 0/0.
- Reset at any time forces IDLE and clears the beat counter, rows_read and the checker state. All outputs go low except req_row/req_bank, which go to 0. An in-flight burst is abandoned and its remaining beats are ignored.

## Timing
- Reset values: req=0, req_row=0, req_bank=0, incr_rd_ptr=0, out_valid=0, out_data=0, out_last=0, busy=0, rows_read=0, err=0, err_cnt=0.
- req rises 1 cycle after IDLE samples en=1 and sdram_empty=0.
- req falls in the cycle after ack is sampled high.
- The first beat is counted no earlier than the cycle after ack.
- Forwarding latency is 1 cycle: out_valid/out_data/out_last are registered copies of rd_valid/rd_data/last-beat, with no backpressure.
- incr_rd_ptr pulses in the cycle after the last beat is sampled, i.e. the same cycle out_last=1.
- The minimum row-to-row gap is 3 cycles of overhead (ADV, SETTLE, IDLE) beyond the burst itself.
- rows_read updates in the cycle after ADV.

## Configuration
- SDRAM_ROW_READER_CHECK_EN defined: a pattern checker is compiled in.
  - It keeps an expected-word counter of DATA_W bits, 0 after reset, incremented on every counted beat.
  - A beat with rd_data ≠ expected sets err, which stays set until reset. err_cnt increments per mismatch and saturates at 0xFFFF.
  - The expected counter always advances, whether or not the beat matched.
  - The checker adds no latency: err and err_cnt update on the same edge as out_valid.
- SDRAM_ROW_READER_CHECK_EN undefined: no checker logic; err and err_cnt are tied to 0.

## Test plan
- Reset then idle: rst=1 then 0 with sdram_empty=1 and en=1 -> req stays 0 and all outputs match their reset values for 20 cycles.
- Single row, BURST_LEN=4: sdram_empty=0, rd_row=5, rd_bank=2, ack 3 cycles after req, data 0..3 -> req_row=5, req_bank=2; out_data 0,1,2,3; out_last with 3; one incr_rd_ptr pulse; rows_read=1; err=0.
- Back-to-back rows: sdram_empty held 0 for 3 rows -> 3 requests, 3 incr_rd_ptr pulses; consecutive requests are ≥3 cycles apart after the preceding last beat; rows_read=3.
- Stray data and en drop: rd_valid pulses in IDLE/REQ are not forwarded, and deasserting en mid-burst still completes the row -> out_valid count = BURST_LEN per row; after that row no new req.
- Checker (macro defined): corrupt beat 2 to 0xFFFF in row 0 -> err=1 from the next cycle on, err_cnt=1, and later correct beats match with no further increments. With the macro undefined, err and err_cnt stay 0.
- Reset mid-burst: assert rst after 2 of 4 beats -> immediate IDLE, no incr_rd_ptr pulse, rows_read=0; the remaining beats are ignored.
